mmio_gpio: RTL and testbench
============================

# mmio_gpio

Parametrised memory-mapped GPIO peripheral on the CPU data bus; replaces the fixed 8-bit LED write decode in the board top level. Provides PIN_COUNT bidirectional pins with output, direction, atomic set/clear/toggle, synchronised input readback and per-pin edge interrupts. Sits beside DataMemory on the data bus; pins go to LEDs, switches or GPIO headers through top-level tristate buffers.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 10, data bus address width
- BASE_ADDR, 10'h200, first address of the 16-word register window (aligned to 16)
- PIN_COUNT, 8, number of pins, 1..DATA_WIDTH
- i_Clock  in  1  system clock, all logic on rising edge
- i_Reset  in  1  asynchronous, active-high reset
- i_Addr  in  ADDR_WIDTH  bus address
- i_WrEnable  in  1  write strobe, one cycle per write
- i_WrData  in  DATA_WIDTH  write data
- o_RdData  out  DATA_WIDTH  registered read data for the address of the previous cycle
- i_PinIn  in  PIN_COUNT  asynchronous pin inputs
- o_PinOut  out  PIN_COUNT  output drive values
- o_PinOE  out  PIN_COUNT  output enables (1 = drive)
- o_Irq  out  1  level interrupt, OR of pending status bits

## Operation
- Selected when i_Addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]; offset = i_Addr[3:0]. Only bits [PIN_COUNT-1:0] are used; upper write bits ignored, upper read bits 0.
- Offset 0 OUT (rw): drives o_PinOut.
- Offset 1 DIR (rw): drives o_PinOE.
- Offset 2 IN (ro): synchronised pin values; writes ignored.
- Offset 3 SET (wo): OUT |= data. Offset 4 CLR (wo): OUT &= ~data. Offset 5 TGL (wo): OUT ^= data. Read as 0.
- Offset 6 RISE_EN (rw), offset 7 FALL_EN (rw): per-pin edge interrupt enables.
- Offset 8 STATUS (rw1c): bit set on an enabled edge of its synchronised input; writing 1 clears, writing 0 no effect.
- Offsets 9-15 reserved: read 0, writes ignored. Unselected addresses: no register change.
- Input path per pin: 2-flop synchroniser → IN; 1 further flop (prev) for edge detect; rise = IN & ~prev, fall = ~IN & prev.
- Same-cycle STATUS W1C and new edge on the same bit: set wins (bit stays 1).
- Clearing an enable does not clear an already pending STATUS bit.
- o_Irq = |STATUS (from registers, no extra delay).

## Timing
- Reset (async): OUT, DIR, RISE_EN, FALL_EN, STATUS, sync/prev flops, o_RdData all 0; o_PinOut=0, o_PinOE=0, o_Irq=0. Release edge-detect uses prev=0, so a pin held high at reset release may raise a rise event only if RISE_EN is already set (it is not, by reset), i.e. no spurious interrupt.
- Write: register updated at the clock edge where i_WrEnable=1; o_PinOut/o_PinOE change at that edge.
- Read: o_RdData valid one cycle after address presented; updated every cycle (no read enable, no side effects).
- Input latency: change settled before edge k → IN updated at edge k+1 → STATUS bit set at edge k+2 → o_Irq high after edge k+2.
- Pulses shorter than one clock period may be missed; not required to be captured.
- Back-to-back writes every cycle supported.

## Structure
- Package gpio_pkg: register offset localparams (GPIO_OUT..GPIO_STATUS), window size, reserved read value.
- Sub-module gpio_sync: per-vector 2-flop synchroniser plus prev flop, outputs sync value, rise and fall vectors; parametrised by WIDTH.
- Top of block: decode, register file, read mux register, irq OR.

## Test plan
- Reset mid-operation: OUT=8'hA5, DIR=8'hFF, STATUS pending, assert i_Reset async → o_PinOut=0, o_PinOE=0, o_Irq=0, o_RdData=0 immediately.
- Atomic ops: write OUT=8'hF0, SET 8'h0F, CLR 8'h30, TGL 8'hFF → o_PinOut sequence F0, FF, CF, 30; read OUT returns 30.
- Input/latency: RISE_EN=8'h01, i_PinIn[0] 0→1 before edge k → IN reads 1 from k+1, STATUS=1 and o_Irq=1 after edge k+2; falling edge does not set status.
- W1C race: write STATUS=1 in the same cycle a new rising edge on pin 0 is detected → STATUS[0] remains 1; later write STATUS=1 alone → o_Irq=0.
- Decode: write 32'hFFFFFFFF to BASE_ADDR+9 and BASE_ADDR+16 → no register changes, reads of offsets 3,4,5,9 return 0, upper bits [31:8] of any read 0.
- Parametrisation: PIN_COUNT=32, BASE_ADDR=10'h300 → TGL 32'h8000_0001 toggles only pins 31 and 0; address 10'h200 ignored.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared register map constants for the memory-mapped GPIO block.
package gpio_pkg;

    localparam logic [3:0] GPIO_OUT     = 4'h0;
    localparam logic [3:0] GPIO_DIR     = 4'h1;
    localparam logic [3:0] GPIO_IN      = 4'h2;
    localparam logic [3:0] GPIO_SET     = 4'h3;
    localparam logic [3:0] GPIO_CLR     = 4'h4;
    localparam logic [3:0] GPIO_TGL     = 4'h5;
    localparam logic [3:0] GPIO_RISE_EN = 4'h6;
    localparam logic [3:0] GPIO_FALL_EN = 4'h7;
    localparam logic [3:0] GPIO_STATUS  = 4'h8;

    localparam int unsigned GPIO_WINDOW_WORDS = 16;
    localparam logic [31:0] GPIO_RSVD_READ    = 32'h0;

endpackage

// File: rtl/mmio_gpio_if.sv
// Data-bus port of the GPIO peripheral: address, write strobe/data and registered read data.
interface mmio_gpio_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] i_Addr;
    logic                  i_WrEnable;
    logic [DATA_WIDTH-1:0] i_WrData;
    logic [DATA_WIDTH-1:0] o_RdData;

    modport master (
        output i_Addr,
        output i_WrEnable,
        output i_WrData,
        input  o_RdData
    );

    modport slave (
        input  i_Addr,
        input  i_WrEnable,
        input  i_WrData,
        output o_RdData
    );
endinterface

// File: rtl/gpio_sync.sv
// Two-flop input synchroniser per bit plus a history flop for rise/fall detection.
module gpio_sync #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_Async,
    output logic [WIDTH-1:0] o_Sync,
    output logic [WIDTH-1:0] o_Rise,
    output logic [WIDTH-1:0] o_Fall
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_Async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_Sync = r_sync;
    assign o_Rise = r_sync & ~r_prev;
    assign o_Fall = ~r_sync & r_prev;
endmodule

// File: rtl/mmio_gpio.sv
// GPIO peripheral: address decode, register file with atomic set/clear/toggle,
// edge-interrupt status (rw1c), registered read mux and level interrupt.
module mmio_gpio
    import gpio_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 10'h200,
    parameter int unsigned           PIN_COUNT  = 8
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    mmio_gpio_if.slave           bus,
    input  logic [PIN_COUNT-1:0] i_PinIn,
    output logic [PIN_COUNT-1:0] o_PinOut,
    output logic [PIN_COUNT-1:0] o_PinOE,
    output logic                 o_Irq
);
    logic                  w_sel;
    logic                  w_wr;
    logic [3:0]            w_off;
    logic [PIN_COUNT-1:0]  w_wdata;
    logic [PIN_COUNT-1:0]  w_sync;
    logic [PIN_COUNT-1:0]  w_rise;
    logic [PIN_COUNT-1:0]  w_fall;
    logic [PIN_COUNT-1:0]  w_out_d;
    logic [PIN_COUNT-1:0]  w_dir_d;
    logic [PIN_COUNT-1:0]  w_rise_en_d;
    logic [PIN_COUNT-1:0]  w_fall_en_d;
    logic [PIN_COUNT-1:0]  w_status_d;
    logic [PIN_COUNT-1:0]  w_w1c;
    logic [DATA_WIDTH-1:0] w_rd_d;
    logic                  w_unused_wdata;

    logic [PIN_COUNT-1:0]  r_out;
    logic [PIN_COUNT-1:0]  r_dir;
    logic [PIN_COUNT-1:0]  r_rise_en;
    logic [PIN_COUNT-1:0]  r_fall_en;
    logic [PIN_COUNT-1:0]  r_status;
    logic [DATA_WIDTH-1:0] r_rd_data;

    gpio_sync #(
        .WIDTH (PIN_COUNT)
    ) u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Async (i_PinIn),
        .o_Sync  (w_sync),
        .o_Rise  (w_rise),
        .o_Fall  (w_fall)
    );

    assign w_sel          = (bus.i_Addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign w_wr           = w_sel && bus.i_WrEnable;
    assign w_off          = bus.i_Addr[3:0];
    assign w_wdata        = bus.i_WrData[PIN_COUNT-1:0];
    assign w_unused_wdata = ^bus.i_WrData;

    always_comb begin
        w_out_d     = r_out;
        w_dir_d     = r_dir;
        w_rise_en_d = r_rise_en;
        w_fall_en_d = r_fall_en;
        w_w1c       = '0;
        if (w_wr) begin
            case (w_off)
                GPIO_OUT:     w_out_d     = w_wdata;
                GPIO_DIR:     w_dir_d     = w_wdata;
                GPIO_SET:     w_out_d     = r_out | w_wdata;
                GPIO_CLR:     w_out_d     = r_out & ~w_wdata;
                GPIO_TGL:     w_out_d     = r_out ^ w_wdata;
                GPIO_RISE_EN: w_rise_en_d = w_wdata;
                GPIO_FALL_EN: w_fall_en_d = w_wdata;
                GPIO_STATUS:  w_w1c       = w_wdata;
                default:      ;
            endcase
        end
        // New edges are OR-ed in after the clear so a same-cycle event wins.
        w_status_d = (r_status & ~w_w1c) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
    end

    always_comb begin
        w_rd_d = DATA_WIDTH'(GPIO_RSVD_READ);
        if (w_sel) begin
            case (w_off)
                GPIO_OUT:     w_rd_d[PIN_COUNT-1:0] = r_out;
                GPIO_DIR:     w_rd_d[PIN_COUNT-1:0] = r_dir;
                GPIO_IN:      w_rd_d[PIN_COUNT-1:0] = w_sync;
                GPIO_RISE_EN: w_rd_d[PIN_COUNT-1:0] = r_rise_en;
                GPIO_FALL_EN: w_rd_d[PIN_COUNT-1:0] = r_fall_en;
                GPIO_STATUS:  w_rd_d[PIN_COUNT-1:0] = r_status;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_rd_data <= '0;
        end else begin
            r_out     <= w_out_d;
            r_dir     <= w_dir_d;
            r_rise_en <= w_rise_en_d;
            r_fall_en <= w_fall_en_d;
            r_status  <= w_status_d;
            r_rd_data <= w_rd_d;
        end
    end

    assign bus.o_RdData = r_rd_data;
    assign o_PinOut     = r_out;
    assign o_PinOE      = r_dir;
    assign o_Irq        = |r_status;
endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio: table of register vectors plus hand sequences for
// input latency, W1C race, enable clear, async reset and a 32-pin instance.
module tb_mmio_gpio;
    logic        clk;
    logic        rst;
    logic [7:0]  pin0;
    logic [7:0]  pout0;
    logic [7:0]  poe0;
    logic        irq0;
    logic [31:0] pin1;
    logic [31:0] pout1;
    logic [31:0] poe1;
    logic        irq1;

    int n_vec;
    int n_err;

    mmio_gpio_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) u_bus0 ();
    mmio_gpio_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) u_bus1 ();

    mmio_gpio #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .BASE_ADDR  (10'h200),
        .PIN_COUNT  (8)
    ) u_dut0 (
        .i_Clock  (clk),
        .i_Reset  (rst),
        .bus      (u_bus0),
        .i_PinIn  (pin0),
        .o_PinOut (pout0),
        .o_PinOE  (poe0),
        .o_Irq    (irq0)
    );

    mmio_gpio #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .BASE_ADDR  (10'h300),
        .PIN_COUNT  (32)
    ) u_dut1 (
        .i_Clock  (clk),
        .i_Reset  (rst),
        .bus      (u_bus1),
        .i_PinIn  (pin1),
        .o_PinOut (pout1),
        .o_PinOE  (poe1),
        .o_Irq    (irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;   // write: {16'h0, OE, OUT}; read: o_RdData
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, bit w, logic [9:0] a, logic [31:0] d, logic [31:0] e);
        vec_t v;
        v.name = n; v.is_wr = w; v.addr = a; v.data = d; v.exp = e;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr0(logic [9:0] a, logic [31:0] d);
        @(negedge clk);
        u_bus0.i_Addr = a; u_bus0.i_WrData = d; u_bus0.i_WrEnable = 1'b1;
        @(posedge clk);
        #1 u_bus0.i_WrEnable = 1'b0;
    endtask

    task automatic rd0(logic [9:0] a, output logic [31:0] d);
        @(negedge clk);
        u_bus0.i_Addr = a; u_bus0.i_WrEnable = 1'b0;
        @(posedge clk);
        #1 d = u_bus0.o_RdData;
    endtask

    task automatic wr1(logic [9:0] a, logic [31:0] d);
        @(negedge clk);
        u_bus1.i_Addr = a; u_bus1.i_WrData = d; u_bus1.i_WrEnable = 1'b1;
        @(posedge clk);
        #1 u_bus1.i_WrEnable = 1'b0;
    endtask

    task automatic rd1(logic [9:0] a, output logic [31:0] d);
        @(negedge clk);
        u_bus1.i_Addr = a; u_bus1.i_WrEnable = 1'b0;
        @(posedge clk);
        #1 d = u_bus1.o_RdData;
    endtask

    initial begin
        logic [31:0] rd;
        n_vec = 0;
        n_err = 0;
        pin0 = '0;
        pin1 = '0;
        u_bus0.i_Addr = '0; u_bus0.i_WrData = '0; u_bus0.i_WrEnable = 1'b0;
        u_bus1.i_Addr = '0; u_bus1.i_WrData = '0; u_bus1.i_WrEnable = 1'b0;
        rst = 1'b1;

        vecs.push_back(mk("out_wr",   1, 10'h200, 32'h0000_00F0, 32'h0000_00F0));
        vecs.push_back(mk("set",      1, 10'h203, 32'h0000_000F, 32'h0000_00FF));
        vecs.push_back(mk("clr",      1, 10'h204, 32'h0000_0030, 32'h0000_00CF));
        vecs.push_back(mk("tgl",      1, 10'h205, 32'h0000_00FF, 32'h0000_0030));
        vecs.push_back(mk("out_rd",   0, 10'h200, 32'h0,         32'h0000_0030));
        vecs.push_back(mk("dir_wr",   1, 10'h201, 32'h0000_00A5, 32'h0000_A530));
        vecs.push_back(mk("dir_rd",   0, 10'h201, 32'h0,         32'h0000_00A5));
        vecs.push_back(mk("set_rd",   0, 10'h203, 32'h0,         32'h0));
        vecs.push_back(mk("clr_rd",   0, 10'h204, 32'h0,         32'h0));
        vecs.push_back(mk("tgl_rd",   0, 10'h205, 32'h0,         32'h0));
        vecs.push_back(mk("rsvd_wr",  1, 10'h209, 32'hFFFF_FFFF, 32'h0000_A530));
        vecs.push_back(mk("unsel_wr", 1, 10'h210, 32'hFFFF_FFFF, 32'h0000_A530));
        vecs.push_back(mk("far_wr",   1, 10'h300, 32'hFFFF_FFFF, 32'h0000_A530));
        vecs.push_back(mk("rsvd_rd",  0, 10'h209, 32'h0,         32'h0));
        vecs.push_back(mk("in_wr",    1, 10'h202, 32'hFFFF_FFFF, 32'h0000_A530));
        vecs.push_back(mk("in_rd",    0, 10'h202, 32'h0,         32'h0));
        vecs.push_back(mk("rise_wr",  1, 10'h206, 32'hFFFF_FFFF, 32'h0000_A530));
        vecs.push_back(mk("rise_rd",  0, 10'h206, 32'h0,         32'h0000_00FF));
        vecs.push_back(mk("rise_off", 1, 10'h206, 32'h0,         32'h0000_A530));
        vecs.push_back(mk("stat_rd",  0, 10'h208, 32'h0,         32'h0));
        vecs.push_back(mk("out_rd2",  0, 10'h200, 32'h0,         32'h0000_0030));
        vecs.push_back(mk("dir_rd2",  0, 10'h201, 32'h0,         32'h0000_00A5));
        vecs.push_back(mk("out_wide", 1, 10'h200, 32'hFFFF_FF3C, 32'h0000_A53C));
        vecs.push_back(mk("out_rd3",  0, 10'h200, 32'h0,         32'h0000_003C));
        vecs.push_back(mk("dir_clr",  1, 10'h201, 32'h0,         32'h0000_003C));

        // Reset state while reset is held.
        #1;
        check("rst_out", {24'h0, pout0}, 32'h0);
        check("rst_oe",  {24'h0, poe0},  32'h0);
        check("rst_irq", {31'h0, irq0},  32'h0);
        check("rst_rd",  u_bus0.o_RdData, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                wr0(vecs[i].addr, vecs[i].data);
                check(vecs[i].name, {16'h0, poe0, pout0}, vecs[i].exp);
            end else begin
                rd0(vecs[i].addr, rd);
                check(vecs[i].name, rd, vecs[i].exp);
            end
        end

        // Input latency: pin change before edge k, IN at k+1, STATUS/irq at k+2.
        wr0(10'h206, 32'h1);
        @(negedge clk);
        pin0[0] = 1'b1;
        u_bus0.i_Addr = 10'h202;
        @(posedge clk); #1;
        check("lat_k_irq", {31'h0, irq0}, 32'h0);
        @(posedge clk); #1;
        check("lat_k1_in", u_bus0.o_RdData, 32'h0);
        check("lat_k1_irq", {31'h0, irq0}, 32'h0);
        @(posedge clk); #1;
        check("lat_k2_in", u_bus0.o_RdData, 32'h1);
        check("lat_k2_irq", {31'h0, irq0}, 32'h1);
        rd0(10'h208, rd);
        check("lat_status", rd, 32'h1);
        wr0(10'h208, 32'h1);
        check("w1c_irq", {31'h0, irq0}, 32'h0);
        @(negedge clk);
        pin0[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("fall_no_irq", {31'h0, irq0}, 32'h0);
        rd0(10'h208, rd);
        check("fall_status", rd, 32'h0);

        // W1C in the same cycle the rise is captured: set wins.
        @(negedge clk);
        pin0[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        u_bus0.i_Addr = 10'h208; u_bus0.i_WrData = 32'h1; u_bus0.i_WrEnable = 1'b1;
        @(posedge clk);
        #1 u_bus0.i_WrEnable = 1'b0;
        check("race_irq", {31'h0, irq0}, 32'h1);
        rd0(10'h208, rd);
        check("race_status", rd, 32'h1);
        wr0(10'h208, 32'h1);
        check("race_clr_irq", {31'h0, irq0}, 32'h0);

        // Falling-edge interrupt; clearing its enable keeps the pending bit.
        wr0(10'h207, 32'h1);
        @(negedge clk);
        pin0[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("fall_irq", {31'h0, irq0}, 32'h1);
        wr0(10'h207, 32'h0);
        check("en_clr_keeps", {31'h0, irq0}, 32'h1);

        // Asynchronous reset mid-operation.
        wr0(10'h200, 32'hA5);
        wr0(10'h201, 32'hFF);
        check("pre_rst_pins", {16'h0, poe0, pout0}, 32'h0000_FFA5);
        rd0(10'h200, rd);
        check("pre_rst_rd", rd, 32'h0000_00A5);
        #2 rst = 1'b1;
        #1;
        check("arst_out", {24'h0, pout0}, 32'h0);
        check("arst_oe",  {24'h0, poe0},  32'h0);
        check("arst_irq", {31'h0, irq0},  32'h0);
        check("arst_rd",  u_bus0.o_RdData, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rd0(10'h206, rd);
        check("arst_rise_en", rd, 32'h0);

        // 32-pin instance at base 10'h300.
        wr1(10'h305, 32'h8000_0001);
        check("p32_tgl", pout1, 32'h8000_0001);
        check("p32_oe", poe1, 32'h0);
        wr1(10'h205, 32'hFFFF_FFFF);
        check("p32_other_base", pout1, 32'h8000_0001);
        rd1(10'h300, rd);
        check("p32_out_rd", rd, 32'h8000_0001);
        check("p32_irq", {31'h0, irq1}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
